var_tap_shifter: RTL and testbench

- Parametrised successor to the team's fixed 8-stage, 4-bit shift delay line.
- Data width and depth are parameters.
- Output comes from a run-time selectable tap, and each stage carries a valid bit alongside its data.
- Adds a synchronous clear, an occupancy counter and a full flag, so datapath control can use it as a programmable-latency delay / alignment buffer.

---
 rtl/var_tap_shifter_pkg.sv | 20 ++
 rtl/var_tap_shifter_shift_stage.sv | 19 +
 rtl/var_tap_shifter.sv | 71 +++++++
 tb/tb_var_tap_shifter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/var_tap_shifter_pkg.sv
// var_tap_shifter_pkg: shared defaults, stage record and width helpers for the tapped delay line.
package var_tap_shifter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

    function automatic int tap_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/var_tap_shifter_shift_stage.sv
// var_tap_shifter_shift_stage: one {valid, data} register of the delay line.
module var_tap_shifter_shift_stage #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= '0;
        else if (clr)  q <= '0;
        else if (shn)  q <= d;
    end

endmodule

// File: rtl/var_tap_shifter.sv
// var_tap_shifter: parametrised delay line with run-time tap select, per-stage valid and occupancy count.
module var_tap_shifter
    import var_tap_shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int TAP_W = tap_w(DEPTH),
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] si,
    input  logic             si_valid,
    input  logic             shn,
    input  logic             clr,
    input  logic [TAP_W-1:0] tap,
    output logic [WIDTH-1:0] so,
    output logic             so_valid,
    output logic [CNT_W-1:0] fill,
    output logic             full
);

    logic [WIDTH:0]   w_d   [DEPTH];
    logic [WIDTH:0]   w_q   [DEPTH];
    logic [WIDTH:0]   w_tab [2**TAP_W];
    logic [CNT_W-1:0] r_fill;
    logic [CNT_W-1:0] w_fill_nxt;
    logic             w_last_v;

    // Taps past the last stage read as an all-zero, invalid stage.
    genvar i;
    generate
        for (i = 0; i < 2**TAP_W; i++) begin : g_stage
            if (i < DEPTH) begin : g_real
                if (i == 0) begin : g_head
                    assign w_d[i] = {si_valid, si};
                end else begin : g_link
                    assign w_d[i] = w_q[i-1];
                end
                var_tap_shifter_shift_stage #(.W(WIDTH + 1)) u_stage (
                    .clk (clk),
                    .rst (rst),
                    .clr (clr),
                    .shn (shn),
                    .d   (w_d[i]),
                    .q   (w_q[i])
                );
                assign w_tab[i] = w_q[i];
            end else begin : g_pad
                assign w_tab[i] = '0;
            end
        end
    endgenerate

    assign {so_valid, so} = w_tab[tap];
    assign w_last_v = w_q[DEPTH-1][WIDTH];

    // Tracks popcount of valid bits: one enters at stage 0, one leaves from the last stage.
    assign w_fill_nxt = (si_valid && !w_last_v) ? r_fill + CNT_W'(1) :
                        (!si_valid && w_last_v) ? r_fill - CNT_W'(1) : r_fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      r_fill <= '0;
        else if (clr)  r_fill <= '0;
        else if (shn)  r_fill <= w_fill_nxt;
    end

    assign fill = r_fill;
    assign full = r_fill == CNT_W'(DEPTH);

endmodule

// File: tb/tb_var_tap_shifter.sv
// tb_var_tap_shifter: directed plan plus random traffic against a stage-array reference model.
module tb_var_tap_shifter;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int TAP_W = 3;
    localparam int CNT_W = 4;

    logic             clk = 0;
    logic             rst = 0;
    logic [WIDTH-1:0] si = '0;
    logic             si_valid = 0;
    logic             shn = 0;
    logic             clr = 0;
    logic [TAP_W-1:0] tap = '0;
    logic [WIDTH-1:0] so;
    logic             so_valid;
    logic [CNT_W-1:0] fill;
    logic             full;

    int n_chk = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_data [DEPTH];
    logic             m_vld  [DEPTH];

    var_tap_shifter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .si       (si),
        .si_valid (si_valid),
        .shn      (shn),
        .clr      (clr),
        .tap      (tap),
        .so       (so),
        .so_valid (so_valid),
        .fill     (fill),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_data[k] = '0;
            m_vld[k]  = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        int pc = 0;
        for (int k = 0; k < DEPTH; k++) pc += int'(m_vld[k]);
        chk({tag, ":fill"}, 32'(fill), 32'(pc));
        chk({tag, ":full"}, 32'(full), 32'(pc == DEPTH));
        chk({tag, ":so"}, 32'(so), int'(tap) < DEPTH ? 32'(m_data[tap]) : 32'd0);
        chk({tag, ":so_valid"}, 32'(so_valid), int'(tap) < DEPTH ? 32'(m_vld[tap]) : 32'd0);
    endtask

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic s, input logic c);
        si_valid = v;
        si       = d;
        shn      = s;
        clr      = c;
        @(posedge clk);
        if (c) model_clear();
        else if (s) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                m_data[k] = m_data[k-1];
                m_vld[k]  = m_vld[k-1];
            end
            m_data[0] = d;
            m_vld[0]  = v;
        end
        #1;
        check_all("cyc");
    endtask

    task automatic sweep(input string tag);
        for (int t = 0; t < DEPTH; t++) begin
            tap = TAP_W'(t);
            #1;
            check_all(tag);
        end
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset:so", 32'(so), 0);
        chk("reset:so_valid", 32'(so_valid), 0);
        chk("reset:fill", 32'(fill), 0);
        chk("reset:full", 32'(full), 0);
        @(negedge clk);
        rst = 1;

        // Legacy latency through tap 7
        tap = 3'd7;
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, WIDTH'(k), 1'b1, 1'b0);
            if (k == 7) chk("lat:early_valid", 32'(so_valid), 0);
            if (k >= 8) chk("lat:so", 32'(so), 32'(k - 7));
        end

        // Asynchronous reset with five valid stages
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) cyc(1'b1, WIDTH'(k), 1'b1, 1'b0);
        chk("arst:pre_fill", 32'(fill), 5);
        tap = 3'd0;
        #2 rst = 0;
        #1;
        model_clear();
        chk("arst:so", 32'(so), 0);
        chk("arst:so_valid", 32'(so_valid), 0);
        chk("arst:fill", 32'(fill), 0);
        chk("arst:full", 32'(full), 0);
        @(negedge clk);
        rst = 1;

        // Tap sweep while holding
        for (int k = 1; k <= 8; k++) cyc(1'b1, WIDTH'(k), 1'b1, 1'b0);
        shn = 0;
        for (int t = 0; t < DEPTH; t++) begin
            tap = TAP_W'(t);
            #1;
            chk("sweep:so", 32'(so), 32'(8 - t));
            chk("sweep:full", 32'(full), 1);
        end
        cyc(1'b1, 4'hE, 1'b0, 1'b0);
        sweep("hold");

        // Bubbles
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b1, 4'hA, 1'b1, 1'b0); chk("bub:fill1", 32'(fill), 1);
        cyc(1'b0, 4'hB, 1'b1, 1'b0); chk("bub:fill2", 32'(fill), 1);
        cyc(1'b1, 4'hC, 1'b1, 1'b0); chk("bub:fill3", 32'(fill), 2);
        cyc(1'b1, 4'hD, 1'b1, 1'b0); chk("bub:fill4", 32'(fill), 3);
        tap = 3'd3; #1;
        chk("bub:so3", 32'(so), 32'hA);
        chk("bub:v3", 32'(so_valid), 1);
        tap = 3'd2; #1;
        chk("bub:so2", 32'(so), 32'hB);
        chk("bub:v2", 32'(so_valid), 0);

        // Clear wins over shift
        for (int k = 1; k <= 8; k++) cyc(1'b1, WIDTH'(k), 1'b1, 1'b0);
        cyc(1'b1, 4'hF, 1'b1, 1'b1);
        chk("clr:fill", 32'(fill), 0);
        chk("clr:full", 32'(full), 0);
        for (int t = 0; t < DEPTH; t++) begin
            tap = TAP_W'(t);
            #1;
            chk("clr:so", 32'(so), 0);
            chk("clr:so_valid", 32'(so_valid), 0);
        end

        // Hold then overflow
        for (int k = 1; k <= 8; k++) cyc(1'b1, WIDTH'(k), 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 4'h5, 1'b0, 1'b0);
        chk("ovf:hold_fill", 32'(fill), 8);
        for (int k = 9; k <= 11; k++) cyc(1'b1, WIDTH'(k), 1'b1, 1'b0);
        tap = 3'd7; #1;
        chk("ovf:fill", 32'(fill), 8);
        chk("ovf:so", 32'(so), 4);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            tap = TAP_W'($urandom_range(0, DEPTH - 1));
            cyc(1'($urandom_range(0, 2) != 0), WIDTH'($urandom),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
